// File: rtl/pingpong_capture_ctrl_pkg.sv
// capture_pkg: shared widths, FSM encoding and bank constants for the sample-RAM write side.
package capture_pkg;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DATA_W  = 10;
    localparam int DEF_DECIM_W = 4;
    localparam int DEF_OVR_W   = 16;
    typedef enum logic {ST_IDLE = 1'b0, ST_FILL = 1'b1} state_e;
    localparam logic BANK_RAM1 = 1'b0;
    localparam logic BANK_RAM2 = 1'b1;
endpackage

// File: rtl/pingpong_capture_ctrl_toggle_sync.sv
// toggle_sync: 2-flop synchronizer for a toggle signal plus a one-cycle pulse per toggle.
module toggle_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tgl_i,
    output logic pulse_o
);
    // [0],[1] synchronizer stages, [2] previous synchronized level
    logic [2:0] sync_q;
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[1:0], tgl_i};
    assign pulse_o = sync_q[2] ^ sync_q[1];
endmodule

// File: rtl/pingpong_capture_ctrl.sv
// pingpong_capture_ctrl: decimating capture into two ping-pong sample RAMs with
// toggle hand-off to the FFT domain; overrun drops the frame instead of touching a bank under read.
module pingpong_capture_ctrl
    import capture_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DECIM_W = DEF_DECIM_W,
    parameter int OVR_W   = DEF_OVR_W
) (
    input  logic               clk_5_12M,
    input  logic               rst_real,
    input  logic               enable,
    input  logic [DECIM_W-1:0] decim,
    input  logic [DATA_W-1:0]  adc_in,
    input  logic               rd_done_tgl,
    output logic [DATA_W-1:0]  wr_data,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic               wren1,
    output logic               wren2,
    output logic               frame_req_tgl,
    output logic               frame_bank,
    output logic               busy,
    output logic [OVR_W-1:0]   overrun_cnt
);
    state_e             state_q, state_d;
    logic [DATA_W-1:0]  adc_q, wr_data_q;
    logic [ADDR_W-1:0]  addr_q, addr_d, wr_addr_q;
    logic [DECIM_W-1:0] cnt_q, cnt_d, decim_lat_q, decim_lat_d;
    logic [OVR_W-1:0]   ovr_q, ovr_d;
    logic wren1_q, wren1_d, wren2_q, wren2_d;
    logic bank_q, bank_d, frame_bank_q, frame_bank_d, req_q, req_d, outst_q, outst_d;
    logic rel, outst_rel, strobe;

    toggle_sync u_done_sync (
        .clk_i  (clk_5_12M),
        .rst_ni (rst_real),
        .tgl_i  (rd_done_tgl),
        .pulse_o(rel)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        decim_lat_d  = decim_lat_q;
        bank_d       = bank_q;
        frame_bank_d = frame_bank_q;
        req_d        = req_q;
        ovr_d        = ovr_q;
        wren1_d      = 1'b0;
        wren2_d      = 1'b0;
        strobe       = 1'b0;
        // release is applied before completion so a same-cycle pair hands off normally
        outst_rel    = outst_q & ~rel;
        outst_d      = outst_rel;
        if (state_q == ST_IDLE) begin
            addr_d = '0;
            cnt_d  = '0;
            if (enable && !(outst_rel && frame_bank_q == bank_q)) begin
                state_d     = ST_FILL;
                decim_lat_d = decim;
            end
        end else if (!enable) begin
            state_d = ST_IDLE;
            addr_d  = '0;
            cnt_d   = '0;
        end else begin
            strobe = (cnt_q == '0);
            cnt_d  = strobe ? decim_lat_q : cnt_q - DECIM_W'(1);
            if (strobe) begin
                wren1_d = (bank_q == BANK_RAM1);
                wren2_d = (bank_q == BANK_RAM2);
                addr_d  = addr_q + ADDR_W'(1);
                if (&addr_q) begin
                    decim_lat_d = decim;
                    cnt_d       = decim;
                    if (outst_rel) begin
                        ovr_d = (&ovr_q) ? ovr_q : ovr_q + OVR_W'(1);
                    end else begin
                        frame_bank_d = bank_q;
                        req_d        = ~req_q;
                        outst_d      = 1'b1;
                        bank_d       = ~bank_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_5_12M or negedge rst_real)
        if (!rst_real) begin
            state_q      <= ST_IDLE;
            adc_q        <= '0;
            wr_data_q    <= '0;
            addr_q       <= '0;
            wr_addr_q    <= '0;
            cnt_q        <= '0;
            decim_lat_q  <= '0;
            ovr_q        <= '0;
            wren1_q      <= 1'b0;
            wren2_q      <= 1'b0;
            bank_q       <= BANK_RAM1;
            frame_bank_q <= 1'b0;
            req_q        <= 1'b0;
            outst_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            adc_q        <= adc_in;
            wr_data_q    <= adc_q ^ {1'b1, {(DATA_W-1){1'b0}}};
            addr_q       <= addr_d;
            wr_addr_q    <= addr_q;
            cnt_q        <= cnt_d;
            decim_lat_q  <= decim_lat_d;
            ovr_q        <= ovr_d;
            wren1_q      <= wren1_d;
            wren2_q      <= wren2_d;
            bank_q       <= bank_d;
            frame_bank_q <= frame_bank_d;
            req_q        <= req_d;
            outst_q      <= outst_d;
        end

    assign wr_data       = wr_data_q;
    assign wr_addr       = wr_addr_q;
    assign wren1         = wren1_q;
    assign wren2         = wren2_q;
    assign frame_req_tgl = req_q;
    assign frame_bank    = frame_bank_q;
    assign busy          = (state_q == ST_FILL);
    assign overrun_cnt   = ovr_q;
endmodule

// File: tb/tb_pingpong_capture_ctrl.sv
// tb_pingpong_capture_ctrl: directed vectors for the offset-binary conversion plus
// hand-written frame, overrun, coincident-release, abort and async-reset sequences.
module tb_pingpong_capture_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, rd_done = 1'b0;
    logic [3:0]  decim = '0;
    logic [9:0]  adc_in = '0;
    logic [9:0]  wr_data, wr_addr;
    logic        wren1, wren2, frame_req_tgl, frame_bank, busy;
    logic [15:0] overrun_cnt;

    int tests = 0, fails = 0;
    int n_w1 = 0, n_w2 = 0, n_tgl = 0, bad_addr = 0, bad_data = 0, snap = 0;
    logic [9:0] exp_addr = '0, m1 = '0, m2 = '0;
    logic prev_tgl = 1'b0, ramp = 1'b0;

    typedef struct { logic [9:0] adc; logic [9:0] exp; } vec_t;
    vec_t vt[6];

    pingpong_capture_ctrl dut (
        .clk_5_12M    (clk),
        .rst_real     (rst_n),
        .enable       (enable),
        .decim        (decim),
        .adc_in       (adc_in),
        .rd_done_tgl  (rd_done),
        .wr_data      (wr_data),
        .wr_addr      (wr_addr),
        .wren1        (wren1),
        .wren2        (wren2),
        .frame_req_tgl(frame_req_tgl),
        .frame_bank   (frame_bank),
        .busy         (busy),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // advance n cycles; inputs change and outputs are sampled on the falling edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            m2 = m1 ^ 10'h200;
            m1 = adc_in;
            @(negedge clk);
            if (wren1 || wren2) begin
                if (wren1) n_w1++;
                if (wren2) n_w2++;
                if (wren1 && wren2) bad_addr++;
                if (wr_addr != exp_addr) bad_addr++;
                if (wr_data != m2) bad_data++;
                exp_addr++;
            end
            if (frame_req_tgl != prev_tgl) n_tgl++;
            prev_tgl = frame_req_tgl;
            if (ramp) adc_in++;
        end
    endtask

    task automatic clr_mon();
        n_w1 = 0; n_w2 = 0; n_tgl = 0; exp_addr = '0; prev_tgl = frame_req_tgl;
    endtask

    initial begin
        vt[0] = '{10'h000, 10'h200};
        vt[1] = '{10'h1FF, 10'h3FF};
        vt[2] = '{10'h200, 10'h000};
        vt[3] = '{10'h3FF, 10'h1FF};
        vt[4] = '{10'h155, 10'h355};
        vt[5] = '{10'h2AA, 10'h0AA};

        repeat (3) @(negedge clk);
        chk("reset_outputs", {wr_data, wr_addr, wren1, wren2, frame_req_tgl, frame_bank, busy, overrun_cnt}, 64'd0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            adc_in = vt[i].adc;
            step(2);
            chk("conv_data", wr_data, vt[i].exp);
            chk("conv_no_wren", {wren1, wren2, busy}, 3'b000);
        end

        // first frame into RAM1 with decim=0 and a ramp on adc_in
        clr_mon();
        adc_in = '0; ramp = 1'b1; decim = 4'd0; enable = 1'b1;
        step(1025);
        chk("f1_ram1_writes", n_w1, 1024);
        chk("f1_ram2_writes", n_w2, 0);
        chk("f1_req_toggles", n_tgl, 1);
        chk("f1_req_level", frame_req_tgl, 1);
        chk("f1_frame_bank", frame_bank, 0);
        chk("f1_busy", busy, 1);
        step(1);
        chk("f2_first_ram2", {wren1, wren2, wr_addr}, {1'b0, 1'b1, 10'd0});

        // no release: RAM2 frame is dropped and RAM1 stays untouched
        step(1023);
        chk("ovr_ram2_writes", n_w2, 1024);
        chk("ovr_ram1_untouched", n_w1, 1024);
        chk("ovr_count", overrun_cnt, 1);
        chk("ovr_no_toggle", n_tgl, 1);
        step(1);
        chk("ovr_same_bank", {wren1, wren2, wr_addr}, {1'b0, 1'b1, 10'd0});
        rd_done = 1'b1;
        step(1023);
        chk("rel_handoff_toggles", n_tgl, 2);
        chk("rel_frame_bank", frame_bank, 1);
        chk("rel_ovr_unchanged", overrun_cnt, 1);
        step(1);
        chk("rel_next_ram1", {wren1, wren2, wr_addr}, {1'b1, 1'b0, 10'd0});

        // synced release pulse lands in the same cycle as the addr 1023 strobe
        step(1020);
        rd_done = 1'b0;
        step(3);
        chk("coinc_handoff", n_tgl, 3);
        chk("coinc_ovr_unchanged", overrun_cnt, 1);
        chk("coinc_frame_bank", frame_bank, 0);

        // abort a RAM2 frame at addr 500, then restart in the same bank
        snap = n_w2;
        step(500);
        chk("abort_pre_writes", n_w2 - snap, 500);
        chk("abort_last_addr", wr_addr, 10'd499);
        enable = 1'b0;
        step(1);
        chk("abort_wren_stops", {wren1, wren2, busy}, 3'b000);
        step(4);
        chk("abort_no_more_writes", n_w2 - snap, 500);
        chk("abort_no_toggle", n_tgl, 3);
        exp_addr = '0;
        enable = 1'b1;
        step(2);
        chk("abort_restart", {wren1, wren2, wr_addr}, {1'b0, 1'b1, 10'd0});

        // asynchronous reset mid-frame
        step(10);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {wr_data, wr_addr, wren1, wren2, frame_req_tgl, frame_bank, busy, overrun_cnt}, 64'd0);
        step(2);
        rst_n = 1'b1;
        clr_mon();
        decim = 4'd3;
        rd_done = 1'b1;
        step(2);
        chk("recover_ram1_addr0", {wren1, wren2, wr_addr}, {1'b1, 1'b0, 10'd0});
        step(3);
        chk("decim_gap", {wren1, wren2}, 2'b00);
        chk("decim_gap_count", n_w1, 1);
        step(1);
        chk("decim_second", {wren1, wr_addr}, {1'b1, 10'd1});
        step(4087);
        chk("decim_not_yet_done", n_tgl, 0);
        chk("decim_writes_pre", n_w1, 1023);
        step(1);
        chk("decim_done_4096", n_tgl, 1);
        chk("decim_writes", n_w1, 1024);
        chk("decim_frame_bank", frame_bank, 0);
        chk("decim_ovr_zero", overrun_cnt, 0);

        chk("addr_sequence_errors", bad_addr, 0);
        chk("data_pipeline_errors", bad_data, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pingpong_capture_ctrl.md
Name: pingpong_capture_ctrl

Overview:
Write-side sequencer for the dual 1024-deep sample RAMs that feed the FFT.
- Converts offset-binary ADC samples to two's complement and applies programmable decimation.
- Generates bank-steered write address and enables, and owns bank ownership.
- Hands completed frames to the 50 MHz FFT domain with a toggle req/done handshake. Overrun is handled by frame drop, never by corrupting a bank under read.

Parameters:
ADDR_W, 10, RAM address width; frame length N = 2^ADDR_W
DATA_W, 10, sample width
DECIM_W, 4, decimation-ratio field width
OVR_W, 16, overrun counter width

Ports:
clk_5_12M  in  1  sample clock
rst_real  in  1  asynchronous, active-low reset
enable  in  1  capture enable, level
decim  in  DECIM_W  keep 1 of (decim+1) samples; sampled at frame start only
adc_in  in  DATA_W  unsigned offset-binary ADC code
rd_done_tgl  in  1  toggles once per released frame (50 MHz domain, async)
wr_data  out  DATA_W  signed sample to both RAM data ports
wr_addr  out  ADDR_W  shared write address
wren1  out  1  RAM1 write enable
wren2  out  1  RAM2 write enable
frame_req_tgl  out  1  toggles once per completed frame
frame_bank  out  1  bank of last handed-off frame (0=RAM1, 1=RAM2); stable while request outstanding
busy  out  1  high in FILL
overrun_cnt  out  OVR_W  dropped frames, saturating

Behaviour:
- Reset value of every output and register is 0. On return from reset, write bank = 0 (RAM1) and no frame is outstanding.
- Datapath:
  - Stage 1 registers adc_in.
  - Stage 2 produces wr_data = reg ^ (1 << (DATA_W-1)), i.e. MSB inverted. Example: 0x1FF -> -1, 0x200 -> 0.
  - wr_addr, wren1 and wren2 are registered and aligned with wr_data.
  - Latency adc_in -> wr_data = 2 cycles.
- Decimation:
  - A counter runs only in FILL. A strobe fires when the counter = 0; the counter reloads with decim_lat (value latched at frame start), else decrements.
  - decim = 0 gives a strobe every cycle.
- States:
  - IDLE: wren1 = wren2 = 0, address counter = 0. Goes to FILL when enable = 1 and write bank is not the outstanding bank.
  - FILL: on each strobe, drive wren of the write bank for one cycle at addr, then addr++. A strobe at addr = N-1 completes the frame and triggers the hand-off below.
  - WAIT: not used. A blocked bank is handled by the drop policy below.
- Hand-off on frame completion:
  - If no frame is outstanding: the cycle after the last write, frame_bank <= write bank, frame_req_tgl toggles, outstanding <= 1, write bank flips, addr <= 0, decim relatched, and FILL continues.
  - Else (overrun): the frame is discarded, write bank is unchanged, addr <= 0, overrun_cnt++ (saturating at all-ones). The outstanding bank is never written.
- Release:
  - rd_done_tgl passes through a 2-flop synchronizer and XOR edge detect. The edge pulse clears outstanding.
  - Release is visible 3 clk_5_12M cycles after the toggle, at worst.
  - If release and completion fall in the same cycle, release is processed first, so the completion hands off normally.
- Enable deasserted in FILL: the partial frame is aborted and state goes to IDLE next cycle. No wren is issued, no request toggles, and outstanding and write bank are kept.
- Unexpected release (done edge with no frame outstanding): ignored, no state change.
- Frame capture time = N*(decim+1) cycles.
- Asynchronous reset mid-frame clears everything immediately. Any in-flight request is lost; the reader re-syncs by comparing toggles after its own reset.

Decomposition:
- Shared package (capture_pkg): ADDR_W/DATA_W defaults, state encoding (ST_IDLE, ST_FILL), bank constants BANK_RAM1 = 0 and BANK_RAM2 = 1.
- One sub-module, toggle_sync: 2-flop synchronizer plus edge pulse, reused on the FFT side for frame_req_tgl.

Test Plan:
- Reset, enable=1, decim=0, ramp adc_in 0..1023 -> 1024 wren1 pulses at addr 0..1023, wr_data = adc^0x200 with 2-cycle lag; frame_req_tgl 0->1, frame_bank=0; next sample goes to RAM2 at addr 0.
- decim=3, continuous -> wren pulses every 4th cycle; frame completes after 4096 cycles.
- No rd_done_tgl after first frame -> second frame (RAM2) completes, overrun_cnt=1, no toggle, RAM1 never written; toggle rd_done -> after the next full RAM2 frame, hand-off with frame_bank=1.
- rd_done_tgl edge timed so its synced pulse coincides with the addr=1023 strobe -> hand-off occurs, overrun_cnt unchanged.
- enable dropped at addr 500 -> wren stops next cycle, no toggle; re-enable -> restart at addr 0, same bank.
- rst_real pulsed mid-frame -> all outputs 0 asynchronously; recovery starts at RAM1 addr 0.
